// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch front end: default datapath widths,
// fetch FSM encoding and a saturating counter helper.
package cpu_pkg;

    localparam int ADDR_W_DEF  = 64;
    localparam int INSTR_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        if (val == 32'hFFFF_FFFF) begin
            return val;
        end else begin
            return val + 32'd1;
        end
    endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Fetch bus bundle: instruction-memory request/response plus the queue head
// presented to IF/ID. master = prefetch queue, slave = memory/consumer side.
interface if_prefetch_queue_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);
    logic               imem_req_valid;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_req_ready;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_instr;
    logic               ifq_valid;
    logic [ADDR_W-1:0]  ifq_pc;
    logic [INSTR_W-1:0] ifq_instr;
    logic               ifq_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_instr,
        output ifq_valid, ifq_pc, ifq_instr,
        input  ifq_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_instr,
        input  ifq_valid, ifq_pc, ifq_instr,
        output ifq_ready
    );
endinterface

// File: rtl/if_prefetch_queue_chk.sv
// Protocol checker for the fetch front end: the memory may only answer while
// a request is outstanding.
module if_prefetch_queue_chk
    import cpu_pkg::*;
(
    input logic         clk,
    input logic         reset,
    input fetch_state_e state,
    input logic         rsp_valid
);
    // A response with nothing outstanding would be silently lost
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(rsp_valid && (state == IDLE)))
                else $error("imem response received with no request outstanding");
        end
    end
endmodule

// File: rtl/ifq_fifo.sv
// Ring buffer of {pc, instr} entries with push/pop/flush; pointers wrap
// modulo DEPTH and the occupancy count is one bit wider than a pointer.
module ifq_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 96,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && !flush && !reset;
    assign do_pop_s  = pop && (count_r != CW'(0));
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Entry storage; the pointers and count decide which slots are meaningful
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy tracking; flush empties the ring in one cycle
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch with one outstanding request,
// DEPTH-entry buffer toward IF/ID, branch redirect flush. Optional counters: IFQ_PERF_CNT_EN.
module if_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    if_prefetch_queue_if.master bus,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_dropped
);
    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    fetch_state_e                state_r;
    logic [ADDR_W-1:0]           fetch_pc_r;
    logic [ADDR_W-1:0]           tag_pc_r;
    logic [CW-1:0]               count_s;
    logic [ADDR_W+INSTR_W-1:0]   head_s;
    logic                        ifq_valid_s;
    logic                        req_valid_s;
    logic                        accept_s;
    logic                        push_s;
    logic                        pop_s;

    // Requests only from IDLE and only with a free slot, so every response has a home
    assign ifq_valid_s = (count_s != CW'(0));
    assign req_valid_s = (state_r == IDLE) && (count_s < DEPTH_C) && !redirect_valid && !reset;
    assign accept_s    = req_valid_s && bus.imem_req_ready;
    assign push_s      = (state_r == WAIT) && bus.imem_rsp_valid && !redirect_valid;
    assign pop_s       = ifq_valid_s && bus.ifq_ready;

    assign bus.imem_req_valid         = req_valid_s;
    assign bus.imem_req_addr          = fetch_pc_r;
    assign bus.ifq_valid              = ifq_valid_s;
    assign {bus.ifq_pc, bus.ifq_instr} = head_s;

    // Fetch sequencer: state, next fetch PC and tag PC of the outstanding request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            tag_pc_r   <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_pc;
            if ((state_r != IDLE) && !bus.imem_rsp_valid) begin
                state_r <= DROP;
            end else begin
                state_r <= IDLE;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        tag_pc_r   <= fetch_pc_r;
                        fetch_pc_r <= fetch_pc_r + ADDR_W'(1);
                        state_r    <= WAIT;
                    end
                end
                WAIT, DROP: begin
                    if (bus.imem_rsp_valid) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect_valid),
        .wdata ({tag_pc_r, bus.imem_rsp_instr}),
        .rdata (head_s),
        .count (count_s)
    );

    if_prefetch_queue_chk u_chk (
        .clk       (clk),
        .reset     (reset),
        .state     (state_r),
        .rsp_valid (bus.imem_rsp_valid)
    );

`ifdef IFQ_PERF_CNT_EN
    logic        drop_s;
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_dropped_r;

    assign drop_s = bus.imem_rsp_valid &&
                    ((state_r == DROP) || ((state_r == WAIT) && redirect_valid));

    // Saturating event counters for enqueued and discarded responses
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_r <= 32'd0;
            perf_dropped_r <= 32'd0;
        end else begin
            if (push_s) begin
                perf_fetched_r <= sat_inc32(perf_fetched_r);
            end
            if (drop_s) begin
                perf_dropped_r <= sat_inc32(perf_dropped_r);
            end
        end
    end

    assign perf_fetched = perf_fetched_r;
    assign perf_dropped = perf_dropped_r;
`else
    assign perf_fetched = 32'd0;
    assign perf_dropped = 32'd0;
`endif
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: behavioural memory + queue model,
// directed scenarios and randomized handshakes.
module tb_if_prefetch_queue;
    import cpu_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'd0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;

    always #5 clk = ~clk;

    if_prefetch_queue_if #(.ADDR_W(64), .INSTR_W(32)) bus ();

    if_prefetch_queue #(
        .DEPTH(DEPTH), .ADDR_W(64), .INSTR_W(32), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .bus(bus), .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
    );

    // reference model: queue contents, next fetch PC, outstanding/stale request
    entry_t      m_q[$];
    logic [63:0] m_fpc;
    logic [63:0] m_tag;
    bit          m_out;
    bit          m_stale;
    int unsigned m_fetched;
    int unsigned m_dropped;
    // memory model
    bit          mem_pend;
    int          mem_rem;
    logic [63:0] mem_addr;
    int          lat_cfg;
    logic [63:0] acc_log[$];
    logic [63:0] pop_log[$];
    int          n_chk;
    int          n_pass;

    function automatic logic [31:0] imem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    // one clock: scoreboard checks, edge, model + memory update
    task automatic step();
        logic        exp_req, acc_m, pop_m, acc_dut, pop_dut, rsp;
        logic [63:0] addr_dut;
        logic [31:0] exp_pf, exp_pd;
        entry_t      head;
        #1;
        exp_req = !reset && !m_out && (m_q.size() < DEPTH) && !redirect_valid;
        n_chk++;
        if (bus.imem_req_valid !== exp_req) $display("FAIL req_valid: got %b expected %b", bus.imem_req_valid, exp_req);
        else n_pass++;
        if (exp_req && bus.imem_req_valid === 1'b1) begin
            n_chk++;
            if (bus.imem_req_addr !== m_fpc) $display("FAIL req_addr: got %h expected %h", bus.imem_req_addr, m_fpc);
            else n_pass++;
        end
        n_chk++;
        if (bus.ifq_valid !== (m_q.size() != 0)) $display("FAIL ifq_valid: got %b expected %b", bus.ifq_valid, m_q.size() != 0);
        else n_pass++;
        if (bus.ifq_valid === 1'b1 && m_q.size() != 0) begin
            head = m_q[0];
            n_chk++;
            if ({bus.ifq_pc, bus.ifq_instr} !== head)
                $display("FAIL ifq_head: got %h/%h expected %h/%h", bus.ifq_pc, bus.ifq_instr, head.pc, head.instr);
            else n_pass++;
        end
`ifdef IFQ_PERF_CNT_EN
        exp_pf = m_fetched;
        exp_pd = m_dropped;
`else
        exp_pf = 32'd0;
        exp_pd = 32'd0;
`endif
        n_chk++;
        if (perf_fetched !== exp_pf || perf_dropped !== exp_pd)
            $display("FAIL perf: got %0d/%0d expected %0d/%0d", perf_fetched, perf_dropped, exp_pf, exp_pd);
        else n_pass++;

        acc_m    = exp_req && bus.imem_req_ready;
        pop_m    = (m_q.size() != 0) && bus.ifq_ready;
        acc_dut  = bus.imem_req_valid && bus.imem_req_ready;
        addr_dut = bus.imem_req_addr;
        pop_dut  = bus.ifq_valid && bus.ifq_ready;
        rsp      = bus.imem_rsp_valid;
        if (pop_dut === 1'b1) pop_log.push_back(bus.ifq_pc);

        @(posedge clk);
        if (reset) begin
            m_q.delete();
            m_fpc = RESET_PC; m_out = 0; m_stale = 0; m_fetched = 0; m_dropped = 0;
            mem_pend = 0;
        end else begin
            if (pop_m) void'(m_q.pop_front());
            if (redirect_valid) begin
                if (rsp && m_out) m_dropped++;
                m_q.delete();
                m_fpc   = redirect_pc;
                m_stale = m_out && !rsp;
                m_out   = m_out && !rsp;
            end else begin
                if (rsp && m_out) begin
                    if (m_stale) m_dropped++;
                    else begin
                        m_q.push_back('{pc: m_tag, instr: imem_word(m_tag)});
                        m_fetched++;
                    end
                    m_out = 0; m_stale = 0;
                end
                if (acc_m) begin
                    m_out = 1; m_tag = m_fpc; m_fpc = m_fpc + 64'd1;
                end
            end
            if (rsp) mem_pend = 0;
            if (acc_dut === 1'b1) begin
                mem_pend = 1;
                mem_addr = addr_dut;
                mem_rem  = (lat_cfg == 0) ? int'($urandom_range(3, 1)) : lat_cfg;
                acc_log.push_back(addr_dut);
            end
        end
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_instr = 32'd0;
        if (mem_pend) begin
            mem_rem--;
            if (mem_rem == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_instr = imem_word(mem_addr);
            end
        end
    endtask

    task automatic do_reset(input int lat);
        lat_cfg = lat;
        reset = 1'b1; redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1; bus.ifq_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        acc_log.delete(); pop_log.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; lat_cfg = 1;
        step(); step();
        #1;
        n_chk++;
        if (bus.ifq_valid !== 1'b0 || bus.imem_req_valid !== 1'b0)
            $display("FAIL reset_outputs: got valid %b req %b expected 0 0", bus.ifq_valid, bus.imem_req_valid);
        else n_pass++;
        n_chk++;
        if (perf_fetched !== 32'd0 || perf_dropped !== 32'd0)
            $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_fetched, perf_dropped);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_chk++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC)
            $display("FAIL reset_first_req: got %b/%h expected 1/%h", bus.imem_req_valid, bus.imem_req_addr, RESET_PC);
        else n_pass++;
    endtask

    task automatic test_sequential();
        do_reset(1);
        for (int i = 0; i < 60 && pop_log.size() < 4; i++) step();
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (i >= pop_log.size() || i >= acc_log.size()) $display("FAIL seq_timeout: only %0d pops", pop_log.size());
            else if (pop_log[i] !== 64'(i) || acc_log[i] !== 64'(i))
                $display("FAIL seq_order[%0d]: got pop %h req %h expected %0d", i, pop_log[i], acc_log[i], i);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        do_reset(1);
        bus.ifq_ready = 1'b0;
        for (int i = 0; i < 20; i++) step();
        #1;
        n_chk++;
        if (acc_log.size() != DEPTH || bus.imem_req_valid !== 1'b0)
            $display("FAIL full_stop: got %0d reqs req_valid %b expected 4 0", acc_log.size(), bus.imem_req_valid);
        else n_pass++;
        bus.ifq_ready = 1'b1;
        for (int i = 0; i < 40 && (pop_log.size() < 4 || acc_log.size() < 5); i++) step();
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (i >= pop_log.size()) $display("FAIL drain_timeout: only %0d pops", pop_log.size());
            else if (pop_log[i] !== 64'(i)) $display("FAIL drain_order[%0d]: got %h expected %0d", i, pop_log[i], i);
            else n_pass++;
        end
        n_chk++;
        if (acc_log.size() < 5) $display("FAIL resume_timeout: got %0d reqs expected 5", acc_log.size());
        else if (acc_log[4] !== 64'd4) $display("FAIL resume_addr: got %h expected 4", acc_log[4]);
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        logic [31:0] exp_pd;
        do_reset(3);
        for (int i = 0; i < 10 && acc_log.size() < 1; i++) step();
        redirect_valid = 1'b1; redirect_pc = 64'h40;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 40 && pop_log.size() < 1; i++) step();
        n_chk++;
        if (pop_log.size() < 1) $display("FAIL redirect_timeout: no pop");
        else if (pop_log[0] !== 64'h40) $display("FAIL redirect_pc: got %h expected 40", pop_log[0]);
        else n_pass++;
`ifdef IFQ_PERF_CNT_EN
        exp_pd = 32'd1;
`else
        exp_pd = 32'd0;
`endif
        n_chk++;
        if (perf_dropped !== exp_pd) $display("FAIL redirect_dropped: got %0d expected %0d", perf_dropped, exp_pd);
        else n_pass++;
    endtask

    task automatic test_redirect_collide();
        bit hit;
        do_reset(2);
        bus.ifq_ready = 1'b0;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step();
            hit = (bus.imem_rsp_valid === 1'b1) && (bus.ifq_valid === 1'b1);
        end
        n_chk++;
        if (!hit) $display("FAIL collide_setup: no rsp with valid head");
        else n_pass++;
        redirect_valid = 1'b1; redirect_pc = 64'h100; bus.ifq_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        pop_log.delete();
        #1;
        n_chk++;
        if (bus.ifq_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h100)
            $display("FAIL collide_after: got valid %b req %b addr %h expected 0 1 100",
                     bus.ifq_valid, bus.imem_req_valid, bus.imem_req_addr);
        else n_pass++;
        for (int i = 0; i < 40 && pop_log.size() < 2; i++) step();
        n_chk++;
        if (pop_log.size() < 2) $display("FAIL collide_timeout: only %0d pops", pop_log.size());
        else if (pop_log[0] !== 64'h100 || pop_log[1] !== 64'h101)
            $display("FAIL collide_refetch: got %h %h expected 100 101", pop_log[0], pop_log[1]);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset(0);
        for (int i = 0; i < 300 && pop_log.size() < 10; i++) begin
            bus.ifq_ready      = 1'($urandom_range(1, 0));
            bus.imem_req_ready = 1'($urandom_range(1, 0));
            step();
        end
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if (i >= pop_log.size()) $display("FAIL wrap_timeout: only %0d pops", pop_log.size());
            else if (pop_log[i] !== 64'(i)) $display("FAIL wrap_order[%0d]: got %h expected %0d", i, pop_log[i], i);
            else n_pass++;
        end
        bus.ifq_ready = 1'b1; bus.imem_req_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        acc_log.delete(); pop_log.delete();
        for (int i = 0; i < 40 && pop_log.size() < 2; i++) step();
        n_chk++;
        if (acc_log.size() < 2 || pop_log.size() < 2) $display("FAIL pcwrap_timeout: %0d reqs %0d pops", acc_log.size(), pop_log.size());
        else if (acc_log[0] !== 64'hFFFF_FFFF_FFFF_FFFF || acc_log[1] !== 64'd0 ||
                 pop_log[0] !== 64'hFFFF_FFFF_FFFF_FFFF || pop_log[1] !== 64'd0)
            $display("FAIL pcwrap: got req %h %h pop %h %h expected all-ones then 0", acc_log[0], acc_log[1], pop_log[0], pop_log[1]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset(3);
        for (int i = 0; i < 10 && acc_log.size() < 1; i++) step();
        step();
        reset = 1'b1;
        step();
        #1;
        n_chk++;
        if (bus.ifq_valid !== 1'b0 || bus.imem_req_valid !== 1'b0)
            $display("FAIL midreset_outputs: got valid %b req %b expected 0 0", bus.ifq_valid, bus.imem_req_valid);
        else n_pass++;
        reset = 1'b0;
        acc_log.delete();
        for (int i = 0; i < 10 && acc_log.size() < 1; i++) step();
        n_chk++;
        if (acc_log.size() < 1) $display("FAIL midreset_timeout: no request");
        else if (acc_log[0] !== RESET_PC) $display("FAIL midreset_addr: got %h expected %h", acc_log[0], RESET_PC);
        else n_pass++;
        for (int i = 0; i < 15; i++) step();
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'd0;
        bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_instr = 32'd0; bus.ifq_ready = 1'b1;
        m_fpc = RESET_PC; m_tag = RESET_PC; m_out = 0; m_stale = 0; m_fetched = 0; m_dropped = 0;
        mem_pend = 0; mem_rem = 0; mem_addr = 64'd0; lat_cfg = 1;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_collide();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
